l1_victim_miss_handler: RTL and testbench
=========================================

# l1_victim_miss_handler

Miss-side initiator for the L1 victim-cache protocol. On an L1 miss it hands the evicted line to the victim cache, looks up the missing line there, and captures the victim-cache data on a hit. On a victim miss it fetches the line from physical memory. It returns one fill line to the L1 controller and keeps saturating hit/miss statistics. It sits between the L1 cache control and both the victim cache and the pmem read port.

## Interface
- width, 256, cache line width in bits
- cnt_width, 16, width of each statistics counter

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk
- miss_req  in  1  L1 miss request; level, sampled only in IDLE
- miss_address  in  32  line address of the missing line
- victim_dirty  in  1  evicted L1 line is dirty
- victim_data  in  width  evicted L1 line
- miss_done  out  1  one-cycle pulse; fill_data valid this cycle
- fill_data  out  width  line for L1 fill; held until next capture
- fill_from_victim  out  1  fill came from victim cache; held with fill_data
- vc_request  out  1  request to victim cache
- vc_address  out  32  lookup/store address (registered miss_address)
- vc_is_dirty  out  1  registered victim_dirty
- vc_evicted_data  out  width  registered victim_data
- vc_resp  in  1  victim cache done
- vc_found  in  1  victim hit; valid only in the first request cycle
- vc_dataout  in  width  victim hit data; valid only in the first request cycle
- pmem_read  out  1  memory read request
- pmem_address  out  32  memory read address
- pmem_rdata  in  width  memory read data, valid with pmem_resp
- pmem_resp  in  1  memory read done
- vc_hit_count  out  cnt_width  saturating count of victim hits
- vc_miss_count  out  cnt_width  saturating count of victim misses

## Operation
- States: IDLE, VC_REQ, MEM_RD, DONE.
- IDLE
  - On miss_req=1, register miss_address, victim_dirty and victim_data into the vc_* output registers.
  - Set first_cycle=1 and go to VC_REQ.
- VC_REQ
  - vc_request=1 every cycle until vc_resp is seen, inclusive.
  - While first_cycle=1, latch hit_flag=vc_found; if vc_found=1, also latch vc_dataout into fill_data. first_cycle then clears.
  - In later VC_REQ cycles, vc_found and vc_dataout are ignored. The victim cache drops them during its writeback.
  - On vc_resp=1:
    - If the hit is latched (hit_flag, or vc_found when vc_resp arrives in the first cycle), set fill_from_victim=1, increment vc_hit_count, and go to DONE.
    - Otherwise, increment vc_miss_count and go to MEM_RD.
- MEM_RD
  - pmem_read=1 and pmem_address=vc_address, held until pmem_resp.
  - On pmem_resp=1, latch pmem_rdata into fill_data, set fill_from_victim=0, and go to DONE.
- DONE
  - miss_done=1 for exactly one cycle, then go to IDLE.
- The L1 controller deasserts miss_req in the cycle after miss_done. A miss_req still high in IDLE is a new miss.
- pmem_read and vc_request are never high in the same cycle. The victim writeback completes before vc_resp, so the memory read never overlaps it.
- Counters saturate at 2^cnt_width-1. Each counter increments at most once per miss.
- Reset
  - Clears all outputs, counters, hit_flag and first_cycle to 0; state returns to IDLE.
  - Reset mid-operation drops the pending miss and emits no miss_done.

## Timing
- All outputs are registered or decoded from state only. There is no combinational input-to-output path.
- Cycle 0: miss_req sampled in IDLE.
- Cycle 1: vc_request=1.
- Victim hit, vc_resp in cycle 1: miss_done in cycle 2 (latency 2).
- vc_resp in cycle n: miss_done in cycle n+1 (hit), or pmem_read from cycle n+1.
- pmem_resp in cycle m: miss_done in cycle m+1.
- fill_data and fill_from_victim are stable from the miss_done cycle until the next miss's capture.

## Test plan
- Clean victim hit: miss_address=0x0000_1040, vc_found=1, vc_dataout={8{32'hA5A5_A5A5}}, vc_resp in cycle 1 -> miss_done in cycle 2, fill_data=A5 pattern, fill_from_victim=1, pmem_read never 1, vc_hit_count=1.
- Victim miss with writeback: vc_found=0, vc_resp in cycle 5, pmem_resp 3 cycles after pmem_read rises, pmem_rdata={8{32'h1234_5678}} ->
  - vc_request high cycles 1-5; pmem_read high cycles 6-8 with pmem_address=miss_address;
  - miss_done in cycle 9, fill_from_victim=0, vc_miss_count=1.
- vc_found=1 in cycle 1 only, then 0 until vc_resp in cycle 4 -> treated as hit, fill_data equals the cycle-1 vc_dataout, no pmem_read.
- rst asserted in the second MEM_RD cycle -> next cycle all outputs and counters are 0, state IDLE, no miss_done; a later miss completes normally.
- cnt_width=4, 17 back-to-back clean victim hits -> vc_hit_count stops at 15, vc_miss_count=0; every miss_done is separated by at least 2 cycles.
- vc_request and pmem_read overlap check across 200 random misses -> never high together, and exactly one miss_done per accepted miss_req.

Source files
------------

// File: rtl/l1_victim_miss_handler.sv
// l1_victim_miss_handler
// Miss-side initiator for the L1 victim-cache protocol. On an L1 miss it hands
// the evicted line to the victim cache and looks up the missing line there.
// On a victim hit it captures the victim data. On a victim miss it reads the
// line from physical memory. It returns one fill line to the L1 controller and
// keeps saturating victim hit/miss counters.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   miss_req, miss_address       L1 miss request (sampled in IDLE) and line address
//   victim_dirty, victim_data    evicted L1 line and its dirty bit
//   miss_done                    one-cycle pulse, fill_data valid
//   fill_data, fill_from_victim  fill line and its source, held until next capture
//   vc_request, vc_address,
//   vc_is_dirty, vc_evicted_data victim-cache request and registered miss context
//   vc_resp, vc_found, vc_dataout victim-cache response (found/data valid in first cycle only)
//   pmem_read, pmem_address      memory read request
//   pmem_rdata, pmem_resp        memory read response
//   vc_hit_count, vc_miss_count  saturating statistics
module l1_victim_miss_handler #(
  parameter int width     = 256,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_req,
  input  logic [31:0]          miss_address,
  input  logic                 victim_dirty,
  input  logic [width-1:0]     victim_data,
  output logic                 miss_done,
  output logic [width-1:0]     fill_data,
  output logic                 fill_from_victim,
  output logic                 vc_request,
  output logic [31:0]          vc_address,
  output logic                 vc_is_dirty,
  output logic [width-1:0]     vc_evicted_data,
  input  logic                 vc_resp,
  input  logic                 vc_found,
  input  logic [width-1:0]     vc_dataout,
  output logic                 pmem_read,
  output logic [31:0]          pmem_address,
  input  logic [width-1:0]     pmem_rdata,
  input  logic                 pmem_resp,
  output logic [cnt_width-1:0] vc_hit_count,
  output logic [cnt_width-1:0] vc_miss_count
);

  typedef enum logic [1:0] {IDLE, VC_REQ, MEM_RD, DONE} state_t;

  state_t state;
  logic   first_cycle;
  logic   hit_flag;

  function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
    return (&v) ? v : v + {{(cnt_width-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      first_cycle      <= 1'b0;
      hit_flag         <= 1'b0;
      miss_done        <= 1'b0;
      fill_data        <= '0;
      fill_from_victim <= 1'b0;
      vc_request       <= 1'b0;
      vc_address       <= '0;
      vc_is_dirty      <= 1'b0;
      vc_evicted_data  <= '0;
      pmem_read        <= 1'b0;
      pmem_address     <= '0;
      vc_hit_count     <= '0;
      vc_miss_count    <= '0;
    end else begin
      case (state)
        // Accept a miss and freeze its context for the whole transaction.
        IDLE: begin
          if (miss_req) begin
            vc_address      <= miss_address;
            vc_is_dirty     <= victim_dirty;
            vc_evicted_data <= victim_data;
            first_cycle     <= 1'b1;
            hit_flag        <= 1'b0;
            vc_request      <= 1'b1;
            state           <= VC_REQ;
          end
        end
        // vc_found/vc_dataout are only meaningful in the first request cycle;
        // afterwards the victim cache is busy writing back and drives junk.
        VC_REQ: begin
          if (first_cycle) begin
            hit_flag    <= vc_found;
            first_cycle <= 1'b0;
            if (vc_found) fill_data <= vc_dataout;
          end
          if (vc_resp) begin
            vc_request <= 1'b0;
            if (hit_flag || (first_cycle && vc_found)) begin
              fill_from_victim <= 1'b1;
              vc_hit_count     <= sat_inc(vc_hit_count);
              miss_done        <= 1'b1;
              state            <= DONE;
            end else begin
              vc_miss_count <= sat_inc(vc_miss_count);
              pmem_read     <= 1'b1;
              pmem_address  <= vc_address;
              state         <= MEM_RD;
            end
          end
        end
        // Victim writeback has finished, so the memory read never overlaps it.
        MEM_RD: begin
          if (pmem_resp) begin
            pmem_read        <= 1'b0;
            fill_data        <= pmem_rdata;
            fill_from_victim <= 1'b0;
            miss_done        <= 1'b1;
            state            <= DONE;
          end
        end
        // miss_done was raised on entry; drop it after one cycle.
        DONE: begin
          miss_done <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_victim_miss_handler.sv
// Testbench for l1_victim_miss_handler: table-driven miss scenarios, a
// mid-operation reset sequence, counter saturation and randomized misses
// checked against a transaction-level reference model.
module tb_l1_victim_miss_handler;

  localparam int W    = 256;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_req;
  logic [31:0]   miss_address;
  logic          victim_dirty;
  logic [W-1:0]  victim_data;
  logic          miss_done;
  logic [W-1:0]  fill_data;
  logic          fill_from_victim;
  logic          vc_request;
  logic [31:0]   vc_address;
  logic          vc_is_dirty;
  logic [W-1:0]  vc_evicted_data;
  logic          vc_resp;
  logic          vc_found;
  logic [W-1:0]  vc_dataout;
  logic          pmem_read;
  logic [31:0]   pmem_address;
  logic [W-1:0]  pmem_rdata;
  logic          pmem_resp;
  logic [CW-1:0] vc_hit_count;
  logic [CW-1:0] vc_miss_count;

  l1_victim_miss_handler #(.width(W), .cnt_width(CW)) dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_address(miss_address),
    .victim_dirty(victim_dirty), .victim_data(victim_data),
    .miss_done(miss_done), .fill_data(fill_data), .fill_from_victim(fill_from_victim),
    .vc_request(vc_request), .vc_address(vc_address), .vc_is_dirty(vc_is_dirty),
    .vc_evicted_data(vc_evicted_data), .vc_resp(vc_resp), .vc_found(vc_found),
    .vc_dataout(vc_dataout), .pmem_read(pmem_read), .pmem_address(pmem_address),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .vc_hit_count(vc_hit_count), .vc_miss_count(vc_miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic         dirty;
    logic [W-1:0] evict;
    logic         found;    // vc_found in the first request cycle
    int           vc_lat;   // cycle of vc_resp (cycle 1 = first request cycle)
    int           mem_lat;  // pmem_resp in the mem_lat-th pmem_read cycle
    logic [W-1:0] vdata;
    logic [W-1:0] mdata;
    int           exp_done; // expected miss_done cycle
    logic         exp_fv;   // expected fill_from_victim
  } vec_t;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  int exp_dones = 0;
  int done_seen = 0;
  int overlap_cnt = 0;
  int gap_err = 0;
  int cyc_n = 0;
  int last_done = -100;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (vc_request === 1'b1 && pmem_read === 1'b1) overlap_cnt++;
    if (miss_done === 1'b1) begin
      done_seen++;
      if (cyc_n - last_done < 3) gap_err++;
      last_done = cyc_n;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_line();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_fill"}, fill_data, '0);
    chk({tag, "_evict"}, vc_evicted_data, '0);
    chk({tag, "_addr"}, W'({vc_address, pmem_address}), '0);
    chk({tag, "_ctrl"}, W'({miss_done, fill_from_victim, vc_request, vc_is_dirty,
                            pmem_read, vc_hit_count, vc_miss_count}), '0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; miss_req = 1'b0; vc_resp = 1'b0; vc_found = 1'b0; pmem_resp = 1'b0;
    step();
    step();
    check_zero(tag);
    rst = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // Reference outcome of one miss from the protocol rules alone.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_fv   = v.found;
    r.exp_done = v.found ? v.vc_lat + 1 : v.vc_lat + v.mem_lat + 1;
    return r;
  endfunction

  task automatic run_miss(input vec_t v);
    int   done_cyc = -1;
    int   pm_cnt = 0;
    bit   vcreq_ok = 1, pm_ok = 1, addr_ok = 1;
    logic exp_pm;
    logic [W-1:0] held;
    // cycle 0
    miss_req = 1'b1; miss_address = v.addr; victim_dirty = v.dirty; victim_data = v.evict;
    vc_resp = 1'b0; pmem_resp = 1'b0;
    vc_found = 1'($urandom); vc_dataout = rand_line(); pmem_rdata = rand_line();
    step();
    miss_req = 1'b0; victim_data = rand_line(); miss_address = $urandom; victim_dirty = ~v.dirty;
    for (int cyc = 1; cyc <= 80 && done_cyc < 0; cyc++) begin
      if (cyc == 1) begin
        chk("vc_address", W'(vc_address), W'(v.addr));
        chk("vc_is_dirty", W'(vc_is_dirty), W'(v.dirty));
        chk("vc_evicted_data", vc_evicted_data, v.evict);
      end
      if (vc_request !== (cyc <= v.vc_lat)) vcreq_ok = 0;
      exp_pm = !v.found && cyc > v.vc_lat && cyc <= v.vc_lat + v.mem_lat;
      if (pmem_read !== exp_pm) pm_ok = 0;
      if (pmem_read === 1'b1 && pmem_address !== v.addr) addr_ok = 0;
      if (miss_done === 1'b1) begin
        done_cyc = cyc;
      end else begin
        vc_found   = (cyc == 1) ? v.found : 1'($urandom);
        vc_dataout = (cyc == 1) ? v.vdata : rand_line();
        vc_resp    = (cyc == v.vc_lat);
        if (pmem_read === 1'b1) pm_cnt++;
        pmem_resp  = (pmem_read === 1'b1) && (pm_cnt == v.mem_lat);
        pmem_rdata = pmem_resp ? v.mdata : rand_line();
        step();
      end
    end
    vc_resp = 1'b0; pmem_resp = 1'b0; vc_found = 1'b0;
    if (v.found) exp_hits = (exp_hits < MAXC) ? exp_hits + 1 : MAXC;
    else         exp_misses = (exp_misses < MAXC) ? exp_misses + 1 : MAXC;
    exp_dones++;
    chk("miss_done_cycle", W'(done_cyc), W'(v.exp_done));
    chk("vc_request_window", W'(vcreq_ok), W'(1));
    chk("pmem_read_window", W'(pm_ok), W'(1));
    chk("pmem_address", W'(addr_ok), W'(1));
    chk("fill_data", fill_data, v.exp_fv ? v.vdata : v.mdata);
    chk("fill_from_victim", W'(fill_from_victim), W'(v.exp_fv));
    chk("vc_hit_count", W'(vc_hit_count), W'(exp_hits));
    chk("vc_miss_count", W'(vc_miss_count), W'(exp_misses));
    held = fill_data;
    step();
    chk("miss_done_pulse", W'(miss_done), W'(0));
    chk("fill_data_held", fill_data, held);
  endtask

  vec_t tbl[5];
  vec_t rv;
  int   seen_before;

  initial begin
    miss_address = '0; victim_dirty = 1'b0; victim_data = '0;
    vc_dataout = '0; pmem_rdata = '0;
    tbl[0] = '{addr:32'h0000_1040, dirty:1'b0, evict:{8{32'h0F0F_0F0F}}, found:1'b1, vc_lat:1,
               mem_lat:1, vdata:{8{32'hA5A5_A5A5}}, mdata:'0, exp_done:2, exp_fv:1'b1};
    tbl[1] = '{addr:32'h0000_2080, dirty:1'b1, evict:{8{32'hCAFE_F00D}}, found:1'b0, vc_lat:5,
               mem_lat:3, vdata:{8{32'h1111_1111}}, mdata:{8{32'h1234_5678}}, exp_done:9, exp_fv:1'b0};
    tbl[2] = '{addr:32'h0000_3000, dirty:1'b1, evict:{8{32'h2222_3333}}, found:1'b1, vc_lat:4,
               mem_lat:1, vdata:{8{32'hDEAD_BEEF}}, mdata:'0, exp_done:5, exp_fv:1'b1};
    tbl[3] = '{addr:32'hFFFF_FFC0, dirty:1'b0, evict:{8{32'h4444_5555}}, found:1'b0, vc_lat:1,
               mem_lat:1, vdata:{8{32'h6666_7777}}, mdata:{8{32'h8888_9999}}, exp_done:3, exp_fv:1'b0};
    tbl[4] = '{addr:32'h0001_0000, dirty:1'b1, evict:{8{32'hAAAA_BBBB}}, found:1'b1, vc_lat:3,
               mem_lat:2, vdata:{8{32'hCCCC_DDDD}}, mdata:'0, exp_done:4, exp_fv:1'b1};

    do_reset("reset");

    for (int i = 0; i < 5; i++) run_miss(tbl[i]);
    chk("table_hit_total", W'(vc_hit_count), W'(3));
    chk("table_miss_total", W'(vc_miss_count), W'(2));

    // Reset in the second MEM_RD cycle drops the miss.
    miss_req = 1'b1; miss_address = 32'h0000_5000; victim_dirty = 1'b1; victim_data = rand_line();
    step();                                   // cycle 1
    miss_req = 1'b0; vc_found = 1'b0; vc_resp = 1'b0;
    step();                                   // cycle 2
    vc_resp = 1'b1;
    step();                                   // cycle 3: first MEM_RD cycle
    vc_resp = 1'b0;
    chk("mid_rst_pmem_read", W'(pmem_read), W'(1));
    step();                                   // cycle 4: second MEM_RD cycle
    chk("mid_rst_pmem_read2", W'(pmem_read), W'(1));
    seen_before = done_seen;
    rst = 1'b1;
    step();
    check_zero("mid_rst");
    rst = 1'b0;
    exp_hits = 0; exp_misses = 0;
    pmem_resp = 1'b1; pmem_rdata = rand_line();
    step();
    pmem_resp = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_rst_no_done", W'(done_seen), W'(seen_before));
    run_miss(tbl[1]);

    // Counter saturation with back-to-back victim hits.
    do_reset("sat_rst");
    for (int i = 0; i < 17; i++) begin
      rv = tbl[0];
      rv.vdata = rand_line();
      run_miss(rv);
    end
    chk("sat_hit_count", W'(vc_hit_count), W'(15));
    chk("sat_miss_count", W'(vc_miss_count), W'(0));

    // Randomized misses against the reference model.
    do_reset("rand_rst");
    for (int i = 0; i < 200; i++) begin
      rv.addr    = {$urandom, 6'b0} & 32'hFFFF_FFC0;
      rv.dirty   = 1'($urandom);
      rv.evict   = rand_line();
      rv.found   = 1'($urandom);
      rv.vc_lat  = $urandom_range(1, 6);
      rv.mem_lat = $urandom_range(1, 5);
      rv.vdata   = rand_line();
      rv.mdata   = rand_line();
      rv = model(rv);
      run_miss(rv);
    end

    step();
    chk("no_overlap", W'(overlap_cnt), W'(0));
    chk("done_per_miss", W'(done_seen), W'(exp_dones));
    chk("done_gap", W'(gap_err), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
